// File: rtl/bridge_pkg.sv
// Shared constants and state encoding for the UART-to-memory-bus debug bridge.
package bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } state_e;

endpackage

// File: rtl/uart_bus_bridge.sv
// Parses 'W'/'R' commands from a UART byte stream, runs one word access on the
// SoC valid/ready bus and answers with read data or an ACK/NAK byte.
module uart_bus_bridge #(
    parameter int SYSTEM_CLK      = 50_000_000,
    parameter int TIMEOUT         = 1024,
    parameter int RX_IDLE_TIMEOUT = SYSTEM_CLK / 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        bus_req,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    import bridge_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(RX_IDLE_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   sh_q, sh_d;
    logic          is_wr_q, is_wr_d;
    logic          multi_q, multi_d;
    logic          mem_valid_q, mem_valid_d;
    logic          bus_req_q, bus_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;
    logic          tx_valid_q, tx_valid_d;

    logic          launch, end_bus, rx_last, idle_exp;
    logic [31:0]   addr_shift, data_shift;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        tmo_d       = tmo_q;
        addr_d      = addr_q;
        sh_d        = sh_q;
        is_wr_d     = is_wr_q;
        multi_d     = multi_q;
        mem_valid_d = mem_valid_q;
        bus_req_d   = bus_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        tx_valid_d  = tx_valid_q;
        launch      = 1'b0;
        end_bus     = 1'b0;
        // Address arrives big-endian, data little-endian.
        addr_shift  = {addr_q[23:0], rx_data};
        data_shift  = {rx_data, sh_q[31:8]};
        rx_last     = (cnt_q == 2'd3);
        idle_exp    = (idle_q == IW'(RX_IDLE_TIMEOUT - 1));

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    cnt_d  = '0;
                    idle_d = '0;
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        is_wr_d = (rx_data == CMD_WR);
                        state_d = ADDR;
                    end else begin
                        sh_d       = {24'h0, RSP_NAK};
                        multi_d    = 1'b0;
                        tx_valid_d = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    addr_d = addr_shift;
                    idle_d = '0;
                    cnt_d  = cnt_q + 2'd1;
                    if (rx_last) begin
                        if (is_wr_q) state_d = DATA;
                        else         launch  = 1'b1;
                    end
                end else if (idle_exp) begin
                    state_d = IDLE;
                    idle_d  = '0;
                    cnt_d   = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            DATA: begin
                if (rx_valid) begin
                    sh_d   = data_shift;
                    idle_d = '0;
                    cnt_d  = cnt_q + 2'd1;
                    if (rx_last) launch = 1'b1;
                end else if (idle_exp) begin
                    state_d = IDLE;
                    idle_d  = '0;
                    cnt_d   = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            BUS: begin
                // Completion takes priority over the terminal timeout count.
                if (mem_ready) begin
                    end_bus = 1'b1;
                    if (is_wr_q) begin
                        sh_d    = {24'h0, RSP_ACK};
                        multi_d = 1'b0;
                    end else begin
                        sh_d    = mem_rdata;
                        multi_d = 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    end_bus = 1'b1;
                    sh_d    = {24'h0, RSP_NAK};
                    multi_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP: begin
                if (tx_valid_q && tx_ready) begin
                    if (!multi_q || cnt_q == 2'd3) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        cnt_d      = '0;
                    end else begin
                        sh_d  = {8'h00, sh_q[31:8]};
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d     = BUS;
            cnt_d       = '0;
            tmo_d       = '0;
            mem_valid_d = 1'b1;
            bus_req_d   = 1'b1;
            mem_addr_d  = {addr_d[31:2], 2'b00};
            mem_wdata_d = is_wr_q ? sh_d : 32'h0;
            mem_wstrb_d = is_wr_q ? 4'hF : 4'h0;
        end

        if (end_bus) begin
            state_d     = RESP;
            cnt_d       = '0;
            tmo_d       = '0;
            mem_valid_d = 1'b0;
            bus_req_d   = 1'b0;
            tx_valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idle_q      <= '0;
            tmo_q       <= '0;
            addr_q      <= '0;
            sh_q        <= '0;
            is_wr_q     <= 1'b0;
            multi_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            bus_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            sh_q        <= sh_d;
            is_wr_q     <= is_wr_d;
            multi_q     <= multi_d;
            mem_valid_q <= mem_valid_d;
            bus_req_q   <= bus_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = sh_q[7:0];
    assign bus_req   = bus_req_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Debug/loader bus initiator driven by a UART byte stream. It parses read and write commands from the receive byte interface and issues single-word transactions on the SoC memory bus, the same `valid`/`ready` bus the CPU drives. It returns read data or ack/nak bytes on the transmit byte interface. It sits beside the CPU behind a bus arbiter and asserts `bus_req` while it owns a transaction.

## Interface
- `TIMEOUT`, default 1024: maximum cycles `mem_valid` may stay high without `mem_ready` before the transaction is aborted.
- `RX_IDLE_TIMEOUT`, default `SYSTEM_CLK/1000`: maximum cycles between received bytes of one command before the parser resets.
- `clk` in 1: system clock.
- `resetn` in 1: synchronous, active-low reset.
- `rx_valid` in 1: single-cycle strobe, `rx_data` is a received byte.
- `rx_data` in 8: received byte.
- `tx_valid` out 1: a byte is offered to the transmitter.
- `tx_data` out 8: byte to transmit.
- `tx_ready` in 1: a byte transfers in any cycle where `tx_valid && tx_ready`.
- `bus_req` out 1: high from the start of BUS state until the transaction ends (arbiter hint).
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: bus completion, a single-cycle pulse.
- `mem_addr` out 32: word address, with bits [1:0] always 0.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: 4'b1111 for write, 4'b0000 for read.
- `mem_rdata` in 32: read data, valid with `mem_ready`.
- `busy` out 1: high in every state except IDLE.

## Operation
- Command framing:
  - Write: 0x57 'W', A3 A2 A1 A0 (address, big-endian), D0 D1 D2 D3 (data, little-endian). Response is 0x06 (ACK), or 0x15 (NAK) on timeout.
  - Read: 0x52 'R', A3..A0. Response is D0 D1 D2 D3 (little-endian), or a single 0x15 on timeout.
  - Any other first byte: respond 0x15 and return to IDLE.
- States:
  - IDLE: wait for `rx_valid`. 'W' or 'R' goes to ADDR. Any other byte goes to RESP with NAK.
  - ADDR: shift in 4 bytes. After the 4th byte, go to DATA for a write or BUS for a read.
  - DATA: shift in 4 bytes, then go to BUS.
  - BUS: drive `mem_valid` until `mem_ready`. Latch `mem_rdata` on a read, then go to RESP. On timeout, go to RESP with NAK.
  - RESP: send 1 or 4 bytes, then go to IDLE.
- `rx_valid` arriving in BUS or RESP is dropped; there is no buffering.
- Byte counter is 2 bits, cleared on every state entry. It wraps at 3 to trigger the state change.
- Inter-byte timer runs in ADDR and DATA and is reloaded on each `rx_valid`. When it expires, go to IDLE silently; no response is sent.
- Bus timeout counter runs only in BUS, sized `$clog2(TIMEOUT+1)`. When it reaches TIMEOUT with no `mem_ready`, drop `mem_valid` and send NAK. A late `mem_ready` after the abort is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- `mem_valid`, `bus_req`, `mem_addr`, `mem_wdata` and `mem_wstrb` rise on the cycle after the final command byte is accepted, and are registered.
- `mem_addr`, `mem_wdata` and `mem_wstrb` are stable for as long as `mem_valid` is high.
- `mem_valid` and `bus_req` fall on the cycle after `mem_ready` is sampled high. That sampling edge also latches `mem_rdata`.
- `mem_ready` in the same cycle as the timeout terminal count: the completion wins and the response is normal.
- `tx_valid` rises on the cycle after BUS exits. Each byte is held until `tx_valid && tx_ready`. The next byte, or IDLE, follows on the next edge.
- Minimum write latency, last rx byte to `tx_valid`: 2 + bus latency cycles.
- `resetn` low in any state aborts with no response. `mem_valid` and `tx_valid` drop on the next edge.

## Structure
- Shared package `bridge_pkg`:
  - Command bytes: `CMD_WR`=8'h57, `CMD_RD`=8'h52.
  - Response bytes: `RSP_ACK`=8'h06, `RSP_NAK`=8'h15.
  - State enum: IDLE, ADDR, DATA, BUS, RESP.
- Single module. The 4-byte shift/serialise register is inline; no sub-module.

## Test plan
- Write: rx 57 80 00 00 10 EF BE AD DE. Expect one bus cycle with `mem_addr`=0x8000_0010, `mem_wdata`=0xDEADBEEF, `mem_wstrb`=4'hF, then tx 06.
- Read: rx 52 80 00 00 13. Expect `mem_addr`=0x8000_0010 (bits [1:0] forced to 0) and `mem_wstrb`=0. With `mem_rdata`=0x12345678, expect tx 78 56 34 12.
- Bus timeout: read with `mem_ready` tied low and `TIMEOUT`=16. Expect `mem_valid` high for exactly 16 cycles, then tx 15. A later `mem_ready` pulse is ignored.
- Bad command: rx 41. Expect tx 15, no `mem_valid`, state returns to IDLE.
- Inter-byte timeout: rx 57 80 00, then silence longer than `RX_IDLE_TIMEOUT`, then a full read command. Expect no tx for the aborted write and a correct read.
- Backpressure and reset: hold `tx_ready` low for 50 cycles during the read response. Expect `tx_data` stable. Assert `resetn`=0 mid-RESP: expect all outputs 0 next cycle, then correct operation after release.
